fdiv_seq: RTL and testbench

//  Iterative IEEE-754 single-precision divider y = a / b for the FP datapath; the inverse

---
 rtl/fdiv_seq.sv | 217 +++++++++++++++++++++
 tb/tb_fdiv_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_seq.sv
// rtl/fdiv_seq.sv - iterative binary32 divider, radix-2 restoring, round-to-nearest-even, RISC-V fflags
module fdiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_input,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             valid_output,
    output logic [4:0]       fflags,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        ROUND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [24:0] rem_q, rem_d;
    logic [25:0] quo_q, quo_d;
    logic [23:0] div_q, div_d;
    logic [9:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic        spec_hit_q, spec_hit_d;
    logic [31:0] spec_y_q, spec_y_d;
    logic [4:0]  spec_f_q, spec_f_d;
    logic [31:0] y_q, y_d;
    logic [4:0]  fflags_q, fflags_d;
    logic        valid_q, valid_d;

    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, a_inf, a_nan, a_snan;
    logic        b_zero, b_inf, b_nan, b_snan;
    logic        sign_in;
    logic [23:0] ma, mb;
    logic        man_small;
    logic [24:0] rem_init;
    logic [9:0]  exp_init;

    assign ea      = a[30:23];
    assign eb      = b[30:23];
    assign fa      = a[22:0];
    assign fb      = b[22:0];
    assign sign_in = a[31] ^ b[31];

    // Denormals are flushed to zero on input, so a zero exponent alone means zero.
    assign a_zero  = (ea == 8'h00);
    assign a_inf   = (ea == 8'hFF) && (fa == 23'd0);
    assign a_nan   = (ea == 8'hFF) && (fa != 23'd0);
    assign a_snan  = a_nan && !fa[22];
    assign b_zero  = (eb == 8'h00);
    assign b_inf   = (eb == 8'hFF) && (fb == 23'd0);
    assign b_nan   = (eb == 8'hFF) && (fb != 23'd0);
    assign b_snan  = b_nan && !fb[22];

    assign ma        = {1'b1, fa};
    assign mb        = {1'b1, fb};
    assign man_small = (ma < mb);
    assign rem_init  = man_small ? {ma, 1'b0} : {1'b0, ma};
    assign exp_init  = {2'b00, ea} - {2'b00, eb} + 10'd127 - {9'd0, man_small};

    logic        spec_hit;
    logic [31:0] spec_y;
    logic [4:0]  spec_f;

    always_comb begin
        spec_hit = 1'b1;
        spec_y   = 32'h7FC0_0000;
        spec_f   = 5'b00000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_f = {a_snan || b_snan || (a_zero && b_zero) || (a_inf && b_inf), 4'b0000};
        end else if (a_inf) begin
            spec_y = {sign_in, 8'hFF, 23'd0};
        end else if (b_zero) begin
            spec_y = {sign_in, 8'hFF, 23'd0};
            spec_f = 5'b01000;
        end else if (b_inf || a_zero) begin
            spec_y = {sign_in, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // One restoring step: trial subtract, keep the difference when it does not go negative.
    logic        step_ge;
    logic [24:0] rem_sub;
    logic [24:0] rem_next;
    logic [25:0] quo_next;

    assign step_ge  = (rem_q >= {1'b0, div_q});
    assign rem_sub  = step_ge ? (rem_q - {1'b0, div_q}) : rem_q;
    assign rem_next = rem_sub << 1;
    assign quo_next = {quo_q[24:0], step_ge};

    logic        rnd_g, rnd_r, rnd_s, rnd_inc, rnd_nx, rnd_carry;
    logic [24:0] mant_sum;
    logic [22:0] mant_frac;
    logic [9:0]  exp_rnd;
    logic        exp_ovf, exp_unf;

    assign rnd_g     = quo_q[1];
    assign rnd_r     = quo_q[0];
    assign rnd_s     = (rem_q != 25'd0);
    assign rnd_inc   = rnd_g && (rnd_r || rnd_s || quo_q[2]);
    assign rnd_nx    = rnd_g || rnd_r || rnd_s;
    assign mant_sum  = {1'b0, quo_q[25:2]} + {24'd0, rnd_inc};
    assign rnd_carry = mant_sum[24];
    assign mant_frac = rnd_carry ? mant_sum[23:1] : mant_sum[22:0];
    assign exp_rnd   = exp_q + {9'd0, rnd_carry};
    assign exp_ovf   = !exp_rnd[9] && (exp_rnd >= 10'd255);
    assign exp_unf   = exp_rnd[9] || (exp_rnd == 10'd0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        div_d      = div_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        spec_hit_d = spec_hit_q;
        spec_y_d   = spec_y_q;
        spec_f_d   = spec_f_q;
        y_d        = y_q;
        fflags_d   = fflags_q;
        valid_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_input) begin
                    state_d    = ITER;
                    cnt_d      = 5'd25;
                    rem_d      = rem_init;
                    quo_d      = 26'd0;
                    div_d      = mb;
                    exp_d      = exp_init;
                    sign_d     = sign_in;
                    spec_hit_d = spec_hit;
                    spec_y_d   = spec_y;
                    spec_f_d   = spec_f;
                end
            end
            ITER: begin
                rem_d = rem_next;
                quo_d = quo_next;
                if (cnt_q == 5'd0) begin
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ROUND: begin
                state_d = IDLE;
                valid_d = 1'b1;
                if (spec_hit_q) begin
                    y_d      = spec_y_q;
                    fflags_d = spec_f_q;
                end else if (exp_ovf) begin
                    y_d      = {sign_q, 8'hFF, 23'd0};
                    fflags_d = 5'b00101;
                end else if (exp_unf) begin
                    y_d      = {sign_q, 31'd0};
                    fflags_d = 5'b00011;
                end else begin
                    y_d      = {sign_q, exp_rnd[7:0], mant_frac};
                    fflags_d = {4'b0000, rnd_nx};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            rem_q      <= 25'd0;
            quo_q      <= 26'd0;
            div_q      <= 24'd0;
            exp_q      <= 10'd0;
            sign_q     <= 1'b0;
            spec_hit_q <= 1'b0;
            spec_y_q   <= 32'd0;
            spec_f_q   <= 5'd0;
            y_q        <= 32'd0;
            fflags_q   <= 5'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            spec_hit_q <= spec_hit_d;
            spec_y_q   <= spec_y_d;
            spec_f_q   <= spec_f_d;
            y_q        <= y_d;
            fflags_q   <= fflags_d;
            valid_q    <= valid_d;
        end
    end

    assign y            = y_q;
    assign fflags       = fflags_q;
    assign valid_output = valid_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fdiv_seq.sv
// tb/tb_fdiv_seq.sv - self-checking bench for fdiv_seq against an arithmetic division model
module tb_fdiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_input = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] y;
    logic        valid_output;
    logic [4:0]  fflags;
    logic        busy;

    fdiv_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_input  (valid_input),
        .a            (a),
        .b            (b),
        .y            (y),
        .valid_output (valid_output),
        .fflags       (fflags),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          due = 0;
    int          acc_cyc = 0;
    bit          pending = 1'b0;
    bit          valid_exp = 1'b0;
    bit          checking = 1'b0;
    logic [31:0] pend_y = 32'd0, cur_y = 32'd0;
    logic [4:0]  pend_f = 5'd0, cur_f = 5'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Quotient from integer division of the scaled significands; rounding decided from the
    // two low quotient bits and the remainder.
    function automatic logic [36:0] ref_div(input logic [31:0] x, input logic [31:0] d);
        logic   s;
        int     ex, ed, e, tail;
        longint mx, md, num, q, r, mant;
        bit     xz, dz, xi, di, xn, dn, xs, ds, st, up;
        s  = x[31] ^ d[31];
        ex = int'(x[30:23]);
        ed = int'(d[30:23]);
        xz = (ex == 0);
        dz = (ed == 0);
        xi = (ex == 255) && (x[22:0] == 0);
        di = (ed == 255) && (d[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);
        dn = (ed == 255) && (d[22:0] != 0);
        xs = xn && !x[22];
        ds = dn && !d[22];
        if (xn || dn || (xz && dz) || (xi && di))
            return {32'h7FC0_0000, (xs || ds || (xz && dz) || (xi && di)), 4'b0000};
        if (xi) return {s, 8'hFF, 23'd0, 5'b00000};
        if (dz) return {s, 8'hFF, 23'd0, 5'b01000};
        if (di || xz) return {s, 31'd0, 5'b00000};
        mx = longint'({1'b1, x[22:0]});
        md = longint'({1'b1, d[22:0]});
        e  = ex - ed + 127;
        if (mx < md) begin
            num = mx << 26;
            e   = e - 1;
        end else begin
            num = mx << 25;
        end
        q    = num / md;
        r    = num % md;
        mant = q >> 2;
        tail = int'(q & 3);
        st   = (r != 0);
        up   = (tail == 3) || ((tail == 2) && (st || mant[0]));
        mant = mant + longint'(up);
        if (mant == (64'sd1 << 24)) begin
            mant = 64'sd1 << 23;
            e    = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0, 5'b00101};
        if (e <= 0) return {s, 31'd0, 5'b00011};
        return {s, e[7:0], mant[22:0], 4'b0000, ((tail != 0) || st)};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 19);
        case (k)
            0: v[30:23] = 8'h00;
            1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            2: begin v[30:23] = 8'hFF; v[22] = 1'b1; end
            3: begin v[30:23] = 8'hFF; v[22] = 1'b0; v[0] = 1'b1; end
            4: v[30:23] = ($urandom_range(0, 1) == 1) ? 8'd1 : 8'd254;
            5, 6, 7, 8, 9, 10: v[30:23] = 8'($urandom_range(100, 154));
            11: begin v[30:23] = 8'($urandom_range(110, 144)); v[22:0] = 23'd0; end
            default: v[30:23] = 8'($urandom_range(1, 254));
        endcase
        return v;
    endfunction

    // Reference timeline: accept when idle, result due 27 edges after the accept edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            cur_y     <= 32'd0;
            cur_f     <= 5'd0;
            valid_exp <= 1'b0;
        end else begin
            cyc       <= cyc + 1;
            valid_exp <= 1'b0;
            if (pending && (cyc + 1 == due)) begin
                cur_y     <= pend_y;
                cur_f     <= pend_f;
                valid_exp <= 1'b1;
                pending   <= 1'b0;
            end
            if (valid_input && !pending) begin
                {pend_y, pend_f} <= ref_div(a, b);
                due              <= cyc + 1 + 27;
                pending          <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("valid_output", 64'(valid_output), 64'(valid_exp));
            chk("busy", 64'(busy), 64'(pending));
            chk("y", 64'(y), 64'(cur_y));
            chk("fflags", 64'(fflags), 64'(cur_f));
        end
    end

    task automatic launch_now(input logic [31:0] x, input logic [31:0] d);
        a           = x;
        b           = d;
        valid_input = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc     = cyc;
        valid_input = 1'b0;
    endtask

    task automatic wait_result(input string nm, input logic [31:0] ey, input logic [4:0] ef);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (valid_output) seen = 1'b1;
        end
        chk({nm, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({nm, "_latency"}, 64'(cyc - acc_cyc), 64'd27);
            chk({nm, "_y"}, 64'(y), 64'(ey));
            chk({nm, "_flags"}, 64'(fflags), 64'(ef));
        end
    endtask

    initial begin
        int          first_acc;
        int          pulses;
        logic [36:0] r;

        r = ref_div(32'h40C0_0000, 32'h4000_0000); chk("model_6div2", 64'(r), {27'd0, 32'h4040_0000, 5'h00});
        r = ref_div(32'h3F80_0000, 32'h4040_0000); chk("model_1div3", 64'(r), {27'd0, 32'h3EAA_AAAB, 5'h01});
        r = ref_div(32'h3F80_0000, 32'h0000_0000); chk("model_1div0", 64'(r), {27'd0, 32'h7F80_0000, 5'h08});
        r = ref_div(32'h0000_0000, 32'h0000_0000); chk("model_0div0", 64'(r), {27'd0, 32'h7FC0_0000, 5'h10});
        r = ref_div(32'h7F7F_FFFF, 32'h3F00_0000); chk("model_ovf", 64'(r), {27'd0, 32'h7F80_0000, 5'h05});
        r = ref_div(32'h0080_0000, 32'h4000_0000); chk("model_unf", 64'(r), {27'd0, 32'h0000_0000, 5'h03});

        repeat (3) @(posedge clk);
        #1;
        checking = 1'b1;
        chk("reset_y", 64'(y), 64'd0);
        chk("reset_flags", 64'(fflags), 64'd0);
        chk("reset_valid", 64'(valid_output), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        launch_now(32'h40C0_0000, 32'h4000_0000);
        chk("busy_after_accept", 64'(busy), 64'd1);
        wait_result("six_div_two", 32'h4040_0000, 5'h00);
        @(posedge clk);
        #1;
        chk("pulse_one_cycle", 64'(valid_output), 64'd0);

        launch_now(32'h3F80_0000, 32'h4040_0000); wait_result("one_third", 32'h3EAA_AAAB, 5'h01);
        launch_now(32'h3F80_0000, 32'h0000_0000); wait_result("div_zero", 32'h7F80_0000, 5'h08);
        launch_now(32'h0000_0000, 32'h0000_0000); wait_result("zero_zero", 32'h7FC0_0000, 5'h10);
        launch_now(32'h7F7F_FFFF, 32'h3F00_0000); wait_result("overflow", 32'h7F80_0000, 5'h05);
        launch_now(32'h0080_0000, 32'h4000_0000); wait_result("underflow", 32'h0000_0000, 5'h03);

        launch_now(32'h40C0_0000, 32'h4000_0000);
        first_acc = acc_cyc;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_on_drop", 64'(busy), 64'd1);
        a = 32'h3F80_0000;
        b = 32'h4040_0000;
        valid_input = 1'b1;
        @(posedge clk);
        #1;
        valid_input = 1'b0;
        acc_cyc = first_acc;
        wait_result("dropped_second", 32'h4040_0000, 5'h00);
        launch_now(32'h3F80_0000, 32'h4040_0000);
        chk("back_to_back_accept", 64'(acc_cyc - first_acc), 64'd28);
        wait_result("back_to_back", 32'h3EAA_AAAB, 5'h01);
        chk("back_to_back_total", 64'(cyc - first_acc), 64'd55);

        launch_now(32'h40C0_0000, 32'h4000_0000);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_y", 64'(y), 64'd0);
        chk("abort_flags", 64'(fflags), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(valid_output), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1;
            if (valid_output) pulses++;
        end
        chk("abort_no_result", 64'(pulses), 64'd0);
        launch_now(32'h3F80_0000, 32'h4040_0000);
        wait_result("after_reset", 32'h3EAA_AAAB, 5'h01);

        for (int i = 0; i < 6000; i++) begin
            a = rand_fp();
            b = rand_fp();
            valid_input = valid_output ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
            @(posedge clk);
            #1;
        end
        valid_input = 1'b0;
        for (int i = 0; i < 40 && pending; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", 64'(pending), 64'd0);
        @(negedge clk);
        checking = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
